// File: rtl/sf2_ram64x18_pkg.sv
// Shared widths, byte-lane bounds and storage types for the SmartFusion2 64x18 micro-RAM model.
package sf2_ram64x18_pkg;

  localparam int SF2_RAM64_ADDR_W = 6;
  localparam int SF2_RAM64_DATA_W = 18;
  localparam int SF2_RAM64_DEPTH  = 64;

  localparam int LANE0_LO = 0;
  localparam int LANE0_HI = 8;
  localparam int LANE1_LO = 9;
  localparam int LANE1_HI = 17;

  typedef logic [SF2_RAM64_ADDR_W-1:0] addr_t;
  typedef logic [SF2_RAM64_DATA_W-1:0] word_t;
  typedef word_t mem_t [SF2_RAM64_DEPTH];

endpackage

// File: rtl/sf2_ram64x18_if.sv
// Write port and both read ports of the 64x18 micro-RAM, grouped as one bus.
interface sf2_ram64x18_if;
  import sf2_ram64x18_pkg::*;

  logic  w_en;
  logic  [1:0] w_be;
  addr_t w_addr;
  word_t w_data;
  logic  a_en;
  addr_t a_addr;
  logic  a_dout_en;
  word_t a_dout;
  logic  b_en;
  addr_t b_addr;
  logic  b_dout_en;
  word_t b_dout;

  modport master (
    output w_en, w_be, w_addr, w_data,
    output a_en, a_addr, a_dout_en,
    output b_en, b_addr, b_dout_en,
    input  a_dout, b_dout
  );

  modport slave (
    input  w_en, w_be, w_addr, w_data,
    input  a_en, a_addr, a_dout_en,
    input  b_en, b_addr, b_dout_en,
    output a_dout, b_dout
  );
endinterface

// File: rtl/sf2_ram64x18_rdport.sv
// One synchronous read port: address-stage capture plus optional output pipeline register.
module sf2_ram64x18_rdport
  import sf2_ram64x18_pkg::*;
#(
  parameter bit DOUT_REG = 1'b0
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  en,
  input  logic  dout_en,
  input  word_t word,
  output word_t dout
);

  word_t rd_p1;
  word_t rd_p2;

  // Stage 1: capture the array word addressed on this edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p1 <= '0;
    end else if (en) begin
      rd_p1 <= word;
    end
  end

  // Stage 2: optional output register, pruned by synthesis when DOUT_REG=0
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p2 <= '0;
    end else if (dout_en) begin
      rd_p2 <= rd_p1;
    end
  end

  assign dout = DOUT_REG ? rd_p2 : rd_p1;

endmodule

// File: rtl/sf2_ram64x18.sv
// SmartFusion2 64x18 micro-RAM: one byte-enabled write port, two independent read ports.
module sf2_ram64x18
  import sf2_ram64x18_pkg::*;
#(
  parameter bit A_DOUT_REG = 1'b0,
  parameter bit B_DOUT_REG = 1'b0,
  parameter logic [SF2_RAM64_DEPTH*SF2_RAM64_DATA_W-1:0] INIT = '0
) (
  input logic CLK,
  input logic RST,
  sf2_ram64x18_if.slave bus
);

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < SF2_RAM64_DEPTH; i++) begin
      m[i] = INIT[i*SF2_RAM64_DATA_W +: SF2_RAM64_DATA_W];
    end
    return m;
  endfunction

  mem_t  mem = init_mem();
  word_t a_word;
  word_t b_word;

  // An unknown write enable poisons the whole array so misuse is visible in gate-level sim
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if ($isunknown(bus.w_en)) begin
        mem <= '{default: 'x};
      end else if (bus.w_en) begin
        if (bus.w_be[0]) mem[bus.w_addr][LANE0_HI:LANE0_LO] <= bus.w_data[LANE0_HI:LANE0_LO];
        if (bus.w_be[1]) mem[bus.w_addr][LANE1_HI:LANE1_LO] <= bus.w_data[LANE1_HI:LANE1_LO];
      end
    end
  end

  // Reads see the pre-edge array, giving read-before-write on address collisions
  always_comb begin
    a_word = $isunknown(bus.a_addr) ? 'x : mem[bus.a_addr];
    b_word = $isunknown(bus.b_addr) ? 'x : mem[bus.b_addr];
  end

  sf2_ram64x18_rdport #(.DOUT_REG(A_DOUT_REG)) u_rd_a (
    .CLK     (CLK),
    .RST     (RST),
    .en      (bus.a_en),
    .dout_en (bus.a_dout_en),
    .word    (a_word),
    .dout    (bus.a_dout)
  );

  sf2_ram64x18_rdport #(.DOUT_REG(B_DOUT_REG)) u_rd_b (
    .CLK     (CLK),
    .RST     (RST),
    .en      (bus.b_en),
    .dout_en (bus.b_dout_en),
    .word    (b_word),
    .dout    (bus.b_dout)
  );

endmodule
